// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave engine: FSM states, the
// clock-mode decode and the fill pattern shifted out when no byte is waiting.
package spi_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2
   } spi_state_e;

   localparam logic [63:0] UDR_FILL = {64{1'b1}};

   function automatic logic sample_on_rise(input logic cpol, input logic cpha);
      return (cpol == cpha);
   endfunction

endpackage

// File: rtl/spi_sync.sv
// Synchronizer for one asynchronous SPI pin; reports the synchronized level
// together with a one-cycle pulse whenever that level has just changed.
module spi_sync
   import spi_pkg::*;
#(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic PCLK,
   input  logic PRESETn,
   input  logic d,
   output logic sync_level,
   output logic sync_toggle
);

   logic [STAGES-1:0] chain_r;
   logic              level_r;
   logic              toggle_r;

   // level_r and toggle_r update together, so a pulse always comes with its new level
   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         chain_r  <= {STAGES{RST_VAL}};
         level_r  <= RST_VAL;
         toggle_r <= 1'b0;
      end else begin
         chain_r  <= {chain_r[STAGES-2:0], d};
         level_r  <= chain_r[STAGES-1];
         toggle_r <= chain_r[STAGES-1] ^ level_r;
      end
   end

   assign sync_level  = level_r;
   assign sync_toggle = toggle_r;

endmodule

// File: rtl/spi_slave_engine.sv
// SPI slave engine on PCLK: oversampled bus pins, one-byte transmit holding
// register, one-byte receive buffer and sticky overrun/underrun status.
module spi_slave_engine
   import spi_pkg::*;
#(
   parameter int DATA_W      = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic              PCLK,
   input  logic              PRESETn,
   input  logic              spe,
   input  logic              cpol,
   input  logic              cpha,
   input  logic              lsbfe,
   input  logic              sck,
   input  logic              ss_n,
   input  logic              mosi,
   output logic              miso,
   output logic              miso_oe,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   input  logic              rx_ack,
   output logic              ovr,
   output logic              udr,
   output logic              busy
);

   localparam int CNT_W = $clog2(DATA_W + 1);

   spi_state_e           state_r;
   logic [DATA_W-1:0]    hold_r;
   logic [DATA_W-1:0]    shift_r;
   logic [DATA_W-1:0]    rx_data_r;
   logic [CNT_W-1:0]     cnt_r;
   logic [SYNC_STAGES:0] mosi_sync_r;
   logic                 tx_ready_r, rx_valid_r, ovr_r, udr_r;
   logic                 miso_r, miso_oe_r, busy_r;
   logic                 cpol_r, cpha_r, lsbfe_r;

   logic                 sck_level_s, sck_toggle_s, ss_level_s, ss_toggle_s;
   logic                 mosi_s, sample_s, shift_edge_s, ss_fall_s, ss_rise_s;
   logic                 abort_s, last_bit_s, consume_s, tx_load_s, udr_set_s;
   logic                 complete_s, rx_room_s;
   logic [DATA_W-1:0]    shift_in_s, load_val_s;

   spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
      .PCLK       (PCLK),
      .PRESETn    (PRESETn),
      .d          (sck),
      .sync_level (sck_level_s),
      .sync_toggle(sck_toggle_s)
   );

   spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss_sync (
      .PCLK       (PCLK),
      .PRESETn    (PRESETn),
      .d          (ss_n),
      .sync_level (ss_level_s),
      .sync_toggle(ss_toggle_s)
   );

   // mosi gets one stage more than the chain so it lines up with the sck edge pulse
   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         mosi_sync_r <= {(SYNC_STAGES + 1){1'b0}};
      end else begin
         mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-1:0], mosi};
      end
   end

   assign mosi_s = mosi_sync_r[SYNC_STAGES];

   // Edge classification, abort detection and shift/load datapath decode
   always_comb begin
      sample_s     = sck_toggle_s & (sck_level_s == sample_on_rise(cpol_r, cpha_r));
      shift_edge_s = sck_toggle_s & (sck_level_s != sample_on_rise(cpol_r, cpha_r));
      ss_fall_s    = ss_toggle_s & ~ss_level_s;
      ss_rise_s    = ss_toggle_s & ss_level_s;
      abort_s      = ss_rise_s | ~spe;
      if (lsbfe_r) begin
         shift_in_s = {mosi_s, shift_r[DATA_W-1:1]};
      end else begin
         shift_in_s = {shift_r[DATA_W-2:0], mosi_s};
      end
      if (tx_ready_r) begin
         load_val_s = UDR_FILL[DATA_W-1:0];
      end else begin
         load_val_s = hold_r;
      end
      last_bit_s = (cnt_r == CNT_W'(DATA_W - 1));
      consume_s  = (state_r == LOAD) & ~abort_s & ~tx_ready_r;
      udr_set_s  = (state_r == LOAD) & ~abort_s & tx_ready_r;
      tx_load_s  = tx_valid & (tx_ready_r | consume_s);
      complete_s = (state_r == SHIFT) & ~abort_s & sample_s & last_bit_s;
      rx_room_s  = ~rx_valid_r | rx_ack;
   end

   // Frame sequencer: mode latch, shift register, bit counter and pin drivers
   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         state_r   <= IDLE;
         shift_r   <= {DATA_W{1'b0}};
         cnt_r     <= {CNT_W{1'b0}};
         miso_r    <= 1'b0;
         miso_oe_r <= 1'b0;
         busy_r    <= 1'b0;
         cpol_r    <= 1'b0;
         cpha_r    <= 1'b0;
         lsbfe_r   <= 1'b0;
      end else begin
         miso_oe_r <= spe & ~ss_level_s;
         case (state_r)
            IDLE: begin
               cpol_r  <= cpol;
               cpha_r  <= cpha;
               lsbfe_r <= lsbfe;
               cnt_r   <= {CNT_W{1'b0}};
               if (spe && ss_fall_s) begin
                  state_r <= LOAD;
                  busy_r  <= 1'b1;
               end
            end
            LOAD: begin
               cnt_r <= {CNT_W{1'b0}};
               if (abort_s) begin
                  state_r <= IDLE;
                  busy_r  <= 1'b0;
               end else begin
                  shift_r <= load_val_s;
                  state_r <= SHIFT;
                  if (!cpha_r) begin
                     miso_r <= lsbfe_r ? load_val_s[0] : load_val_s[DATA_W-1];
                  end
               end
            end
            SHIFT: begin
               if (abort_s) begin
                  state_r <= IDLE;
                  busy_r  <= 1'b0;
                  cnt_r   <= {CNT_W{1'b0}};
               end else if (sample_s) begin
                  shift_r <= shift_in_s;
                  if (last_bit_s) begin
                     cnt_r   <= {CNT_W{1'b0}};
                     state_r <= ss_level_s ? IDLE : LOAD;
                     busy_r  <= ~ss_level_s;
                  end else begin
                     cnt_r <= cnt_r + CNT_W'(1'b1);
                  end
               end else if (shift_edge_s && (cpha_r || (cnt_r != {CNT_W{1'b0}}))) begin
                  // with cpha=0 the shift edge trailing the last sample must not advance miso
                  miso_r <= lsbfe_r ? shift_r[0] : shift_r[DATA_W-1];
               end
            end
            default: begin
               state_r <= IDLE;
               busy_r  <= 1'b0;
               cnt_r   <= {CNT_W{1'b0}};
            end
         endcase
      end
   end

   // Transmit holding register; a load may refill it in the same cycle LOAD drains it
   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         hold_r     <= {DATA_W{1'b0}};
         tx_ready_r <= 1'b1;
      end else if (tx_load_s) begin
         hold_r     <= tx_data;
         tx_ready_r <= 1'b0;
      end else if (consume_s) begin
         tx_ready_r <= 1'b1;
      end
   end

   // Receive buffer and sticky flags; an ack in the completing cycle frees the buffer first
   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         rx_data_r  <= {DATA_W{1'b0}};
         rx_valid_r <= 1'b0;
         ovr_r      <= 1'b0;
         udr_r      <= 1'b0;
      end else begin
         if (complete_s && rx_room_s) begin
            rx_data_r  <= shift_in_s;
            rx_valid_r <= 1'b1;
         end else if (rx_ack) begin
            rx_valid_r <= 1'b0;
         end
         ovr_r <= (ovr_r & ~rx_ack) | (complete_s & ~rx_room_s);
         udr_r <= (udr_r & ~rx_ack) | udr_set_s;
      end
   end

   assign miso     = miso_r;
   assign miso_oe  = miso_oe_r;
   assign tx_ready = tx_ready_r;
   assign rx_data  = rx_data_r;
   assign rx_valid = rx_valid_r;
   assign ovr      = ovr_r;
   assign udr      = udr_r;
   assign busy     = busy_r;

endmodule
